// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use stall,
// branch flush, data-memory freeze with timeout, and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_BITS     = 5,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned MAX_MEM_WAIT = 15,
    parameter int unsigned FLUSH_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [REG_BITS-1:0]  id_rs1,
    input  logic [REG_BITS-1:0]  id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_BITS-1:0]  ex_rs1,
    input  logic [REG_BITS-1:0]  ex_rs2,
    input  logic [REG_BITS-1:0]  ex_rd,
    input  logic                 ex_is_load,
    input  logic [REG_BITS-1:0]  mem_rd,
    input  logic [REG_BITS-1:0]  wb_rd,
    input  logic                 mem_reg_wr,
    input  logic                 wb_reg_wr,
    input  logic                 branch_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    output logic                 stall_fetch,
    output logic                 stall_dec,
    output logic                 bubble_ex,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 freeze,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(MAX_MEM_WAIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               load_use;
    logic               mem_busy;

    // Forwarding selects and hazard priority: freeze > branch flush > load-use stall
    always_comb begin
        forward_a   = 2'b00;
        forward_b   = 2'b00;
        stall_fetch = 1'b0;
        stall_dec   = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        freeze      = 1'b0;

        if (mem_reg_wr && (mem_rd != '0) && (mem_rd == ex_rs1))
            forward_a = 2'b10;
        else if (wb_reg_wr && (wb_rd != '0) && (wb_rd == ex_rs1))
            forward_a = 2'b01;

        if (mem_reg_wr && (mem_rd != '0) && (mem_rd == ex_rs2))
            forward_b = 2'b10;
        else if (wb_reg_wr && (wb_rd != '0) && (wb_rd == ex_rs2))
            forward_b = 2'b01;

        load_use = ex_is_load && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
        mem_busy = dmem_req && !dmem_ready;

        if ((state == ERROR) || mem_busy) begin
            freeze = 1'b1;
        end else if (branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = (FLUSH_DEPTH == 2);
        end else if (load_use) begin
            stall_fetch = 1'b1;
            stall_dec   = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    // Memory-wait tracking; ERROR is absorbing until reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MAX_MEM_WAIT)) begin
                        state       <= ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state       <= ERROR;
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((freeze || stall_fetch) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (flush_if_id && (flush_count != '1))
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: instance a (4-bit counters, short timeout, two-deep flush)
// and instance b (defaults with single-deep flush) share the same stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, mem_reg_wr, wb_reg_wr;
    logic       branch_taken, dmem_req, dmem_ready;

    logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
    logic        a_stf, a_std, a_bub, a_fif, a_fie, a_frz, a_tmo;
    logic        b_stf, b_std, b_bub, b_fif, b_fie, b_frz, b_tmo;
    logic [3:0]  a_stall, a_flush;
    logic [15:0] b_stall, b_flush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_BITS(5), .CNT_WIDTH(4), .MAX_MEM_WAIT(4), .FLUSH_DEPTH(2)) u_a (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .forward_a(a_fwd_a), .forward_b(a_fwd_b),
        .stall_fetch(a_stf), .stall_dec(a_std), .bubble_ex(a_bub),
        .flush_if_id(a_fif), .flush_id_ex(a_fie), .freeze(a_frz), .mem_timeout(a_tmo),
        .stall_cycles(a_stall), .flush_count(a_flush)
    );

    pipeline_hazard_ctrl #(.REG_BITS(5), .CNT_WIDTH(16), .MAX_MEM_WAIT(15), .FLUSH_DEPTH(1)) u_b (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .forward_a(b_fwd_a), .forward_b(b_fwd_b),
        .stall_fetch(b_stf), .stall_dec(b_std), .bubble_ex(b_bub),
        .flush_if_id(b_fif), .flush_id_ex(b_fie), .freeze(b_frz), .mem_timeout(b_tmo),
        .stall_cycles(b_stall), .flush_count(b_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
        mem_reg_wr = 1'b0; wb_reg_wr = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    endtask

    initial begin
        // Reset state
        clear_inputs();
        rstn = 1'b0;
        #2;
        chk("rst_freeze", 32'(a_frz), 32'd0);
        chk("rst_timeout", 32'(a_tmo), 32'd0);
        chk("rst_stall_cnt", 32'(a_stall), 32'd0);
        chk("rst_flush_cnt", 32'(a_flush), 32'd0);
        tick();
        rstn = 1'b1;
        #1;

        // Forwarding priority
        ex_rs1 = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
        #1;
        chk("fwd_a_exmem", 32'(a_fwd_a), 32'd2);
        mem_reg_wr = 1'b0;
        #1;
        chk("fwd_a_memwb", 32'(a_fwd_a), 32'd1);
        ex_rs2 = 5'd5; mem_reg_wr = 1'b1;
        #1;
        chk("fwd_b_exmem", 32'(a_fwd_b), 32'd2);
        ex_rs1 = '0; ex_rs2 = '0; mem_rd = '0; wb_rd = '0;
        #1;
        chk("fwd_a_x0", 32'(a_fwd_a), 32'd0);
        chk("fwd_b_x0", 32'(a_fwd_b), 32'd0);
        clear_inputs();

        // Load-use stall for exactly one cycle
        set_load_use();
        #1;
        chk("lu_stall_fetch", 32'(a_stf), 32'd1);
        chk("lu_stall_dec", 32'(a_std), 32'd1);
        chk("lu_bubble", 32'(a_bub), 32'd1);
        tick();
        chk("lu_stall_cnt", 32'(a_stall), 32'd1);
        ex_is_load = 1'b0;
        #1;
        chk("lu_released", 32'(a_stf), 32'd0);
        tick();
        chk("lu_stall_cnt_hold", 32'(a_stall), 32'd1);
        ex_is_load = 1'b1; id_use_rs2 = 1'b0;
        #1;
        chk("lu_unused_rs2", 32'(a_stf), 32'd0);
        clear_inputs();

        // Branch overrides load-use
        set_load_use();
        branch_taken = 1'b1;
        #1;
        chk("br_flush_if_id", 32'(a_fif), 32'd1);
        chk("br_flush_id_ex_d2", 32'(a_fie), 32'd1);
        chk("br_flush_id_ex_d1", 32'(b_fie), 32'd0);
        chk("br_no_stall", 32'(a_stf), 32'd0);
        chk("br_no_bubble", 32'(a_bub), 32'd0);
        tick();
        chk("br_flush_cnt", 32'(a_flush), 32'd1);
        chk("br_stall_cnt", 32'(a_stall), 32'd1);
        clear_inputs();

        // Memory wait: three frozen cycles then ready
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) branch_taken = 1'b1;
            #1;
            chk($sformatf("mw_freeze_%0d", i), 32'(a_frz), 32'd1);
            chk($sformatf("mw_no_flush_%0d", i), 32'(a_fif), 32'd0);
            tick();
            branch_taken = 1'b0;
        end
        chk("mw_fwd_valid", 32'(a_fwd_a), 32'd2);
        dmem_ready = 1'b1;
        #1;
        chk("mw_ready_unfreeze", 32'(a_frz), 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("mw_stall_cnt", 32'(a_stall), 32'd3);
        chk("mw_flush_cnt", 32'(a_flush), 32'd0);
        chk("mw_back_run", 32'(a_frz), 32'd0);

        // Timeout: MAX_MEM_WAIT=4 gives five freeze cycles then ERROR
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("to_not_yet", 32'(a_tmo), 32'd0);
        tick();
        chk("to_sticky", 32'(a_tmo), 32'd1);
        chk("to_stall_cnt", 32'(a_stall), 32'd5);
        dmem_ready = 1'b1; branch_taken = 1'b1;
        #1;
        chk("to_freeze_held", 32'(a_frz), 32'd1);
        chk("to_no_flush", 32'(a_fif), 32'd0);
        tick();
        chk("to_still_error", 32'(a_tmo), 32'd1);
        do_reset();
        chk("to_rst_timeout", 32'(a_tmo), 32'd0);
        chk("to_rst_freeze", 32'(a_frz), 32'd0);
        chk("to_rst_stall_cnt", 32'(a_stall), 32'd0);

        // Saturation: 20 load-use cycles
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        chk("sat_4bit", 32'(a_stall), 32'd15);
        chk("sat_16bit", 32'(b_stall), 32'd20);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
